// File: rtl/div_restoring.sv
// div_restoring
// Sequential signed 32-bit divider using restoring shift-subtract, one
// quotient bit per clock. Writes the quotient to Lo and the remainder to Hi
// (quotient truncates toward zero, remainder takes the dividend's sign).
//
// Ports:
//   clock     in   rising-edge clock
//   DivReset  in   synchronous active-high reset
//   DivCtrl   in   start pulse; A and B sampled on the same edge
//   A         in   dividend (two's complement)
//   B         in   divisor (two's complement)
//   Hi        out  remainder (registered)
//   Lo        out  quotient (registered)
//   DivDone   out  one-cycle pulse when Hi/Lo update or DivZero rises
//   DivZero   out  sticky divide-by-zero flag, cleared by next start/reset
//   DivBusy   out  high while a division is in progress
`timescale 1ns/1ps
module div_restoring (
   input  logic        clock,
   input  logic        DivReset,
   input  logic        DivCtrl,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] Hi,
   output logic [31:0] Lo,
   output logic        DivDone,
   output logic        DivZero,
   output logic        DivBusy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t      state_r;
   logic [32:0] rem_r;     // partial remainder R
   logic [31:0] quo_r;     // dividend shifting out / quotient shifting in
   logic [31:0] dvs_r;     // divisor magnitude D
   logic [5:0]  cnt_r;     // iteration counter
   logic        sq_r;      // quotient sign
   logic        sr_r;      // remainder sign (sign of dividend)

   logic [33:0] shifted_s;
   logic [33:0] trial_s;

   // Unsigned magnitude; the most negative value maps to 0x80000000.
   function automatic logic [31:0] mag(input logic [31:0] x);
      mag = x[31] ? (32'd0 - x) : x;
   endfunction

   // Shift {R,Q} left by one and form the trial subtraction. R < D <= 2^31
   // always holds, so the top bit of the shifted value stays zero and a
   // borrow shows up in trial_s[33].
   always_comb begin
      shifted_s = {rem_r, quo_r[31]};
      trial_s   = shifted_s - {2'b00, dvs_r};
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clock) begin
      if (DivReset) begin
         state_r <= IDLE;
         rem_r   <= 33'd0;
         quo_r   <= 32'd0;
         dvs_r   <= 32'd0;
         cnt_r   <= 6'd0;
         sq_r    <= 1'b0;
         sr_r    <= 1'b0;
         Hi      <= 32'd0;
         Lo      <= 32'd0;
         DivDone <= 1'b0;
         DivZero <= 1'b0;
         DivBusy <= 1'b0;
      end else if (DivCtrl) begin
         // A start from any state aborts whatever was running.
         if (B == 32'd0) begin
            DivZero <= 1'b1;
            DivDone <= 1'b1;
            DivBusy <= 1'b0;
            state_r <= IDLE;
         end else begin
            quo_r   <= mag(A);
            dvs_r   <= mag(B);
            rem_r   <= 33'd0;
            cnt_r   <= 6'd0;
            sq_r    <= A[31] ^ B[31];
            sr_r    <= A[31];
            DivZero <= 1'b0;
            DivDone <= 1'b0;
            DivBusy <= 1'b1;
            state_r <= RUN;
         end
      end else begin
         DivDone <= 1'b0;
         case (state_r)
            IDLE: begin
               DivBusy <= 1'b0;
            end
            RUN: begin
               if (trial_s[33] == 1'b0) begin
                  rem_r <= trial_s[32:0];
                  quo_r <= {quo_r[30:0], 1'b1};
               end else begin
                  rem_r <= shifted_s[32:0];
                  quo_r <= {quo_r[30:0], 1'b0};
               end
               cnt_r <= cnt_r + 6'd1;
               if (cnt_r == 6'd31) begin
                  state_r <= FIX;
               end else begin
                  state_r <= RUN;
               end
            end
            FIX: begin
               Lo      <= sq_r ? (32'd0 - quo_r) : quo_r;
               Hi      <= sr_r ? (32'd0 - rem_r[31:0]) : rem_r[31:0];
               DivDone <= 1'b1;
               DivBusy <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               DivBusy <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_restoring.sv
`timescale 1ns/1ps
module tb_div_restoring;

   logic        clock;
   logic        DivReset;
   logic        DivCtrl;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] Hi;
   logic [31:0] Lo;
   logic        DivDone;
   logic        DivZero;
   logic        DivBusy;

   int pass_cnt;
   int total_cnt;

   div_restoring dut (
      .clock    (clock),
      .DivReset (DivReset),
      .DivCtrl  (DivCtrl),
      .A        (A),
      .B        (B),
      .Hi       (Hi),
      .Lo       (Lo),
      .DivDone  (DivDone),
      .DivZero  (DivZero),
      .DivBusy  (DivBusy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Pulse DivCtrl for one rising edge; returns just after that edge (negedge).
   task automatic start(input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      A = a;
      B = b;
      DivCtrl = 1'b1;
      @(negedge clock);
      DivCtrl = 1'b0;
      A = 32'hDEADBEEF;
      B = 32'h0;
   endtask

   // Wait (bounded) for DivDone; k = number of edges after the start edge.
   task automatic wait_done(output int k);
      k = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock);
         #1;
         if (DivDone === 1'b1) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      DivReset = 1'b1;
      repeat (2) @(negedge clock);
      DivReset = 1'b0;
      total_cnt++;
      if (Hi !== 32'd0) $display("FAIL reset_hi: got %h want 0", Hi); else pass_cnt++;
      total_cnt++;
      if (Lo !== 32'd0) $display("FAIL reset_lo: got %h want 0", Lo); else pass_cnt++;
      total_cnt++;
      if (DivDone !== 1'b0) $display("FAIL reset_done: got %b want 0", DivDone); else pass_cnt++;
      total_cnt++;
      if (DivZero !== 1'b0) $display("FAIL reset_zero: got %b want 0", DivZero); else pass_cnt++;
      total_cnt++;
      if (DivBusy !== 1'b0) $display("FAIL reset_busy: got %b want 0", DivBusy); else pass_cnt++;
   endtask

   task automatic test_basic();
      int k;
      int busy_cycles;
      start(32'd100, 32'd7);
      // After the start edge DivBusy is high; count busy through edge N+32.
      busy_cycles = (DivBusy === 1'b1) ? 1 : 0;
      k = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock);
         #1;
         if (DivBusy === 1'b1) busy_cycles++;
         if (DivDone === 1'b1) begin
            k = i;
            break;
         end
      end
      total_cnt++;
      if (k != 33) $display("FAIL basic_latency: got %0d want 33", k); else pass_cnt++;
      total_cnt++;
      if (busy_cycles != 33) $display("FAIL basic_busy_cycles: got %0d want 33", busy_cycles); else pass_cnt++;
      total_cnt++;
      if (Lo !== 32'd14) $display("FAIL basic_lo: got %h want %h", Lo, 32'd14); else pass_cnt++;
      total_cnt++;
      if (Hi !== 32'd2) $display("FAIL basic_hi: got %h want %h", Hi, 32'd2); else pass_cnt++;
      total_cnt++;
      if (DivZero !== 1'b0) $display("FAIL basic_zero: got %b want 0", DivZero); else pass_cnt++;
      total_cnt++;
      if (DivBusy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", DivBusy); else pass_cnt++;
      @(posedge clock);
      #1;
      total_cnt++;
      if (DivDone !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", DivDone); else pass_cnt++;
      repeat (5) @(posedge clock);
      #1;
      total_cnt++;
      if (Lo !== 32'd14 || Hi !== 32'd2)
         $display("FAIL basic_hold: got lo=%h hi=%h want lo=%h hi=%h", Lo, Hi, 32'd14, 32'd2);
      else pass_cnt++;
   endtask

   task automatic test_signs();
      logic [31:0] va [6];
      logic [31:0] vb [6];
      logic [31:0] eq [6];
      logic [31:0] er [6];
      int k;
      va[0] = 32'hFFFFFF9C; vb[0] = 32'd7;        eq[0] = 32'hFFFFFFF2; er[0] = 32'hFFFFFFFE;
      va[1] = 32'd100;      vb[1] = 32'hFFFFFFF9; eq[1] = 32'hFFFFFFF2; er[1] = 32'd2;
      va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF; eq[2] = 32'h80000000; er[2] = 32'd0;
      va[3] = 32'h80000000; vb[3] = 32'd2;        eq[3] = 32'hC0000000; er[3] = 32'd0;
      va[4] = 32'd7;        vb[4] = 32'd100;      eq[4] = 32'd0;        er[4] = 32'd7;
      va[5] = 32'hFFFFFFF9; vb[5] = 32'hFFFFFFFE; eq[5] = 32'd3;        er[5] = 32'hFFFFFFFF;
      for (int i = 0; i < 6; i++) begin
         start(va[i], vb[i]);
         wait_done(k);
         total_cnt++;
         if (k != 33 || Lo !== eq[i] || Hi !== er[i] || DivZero !== 1'b0)
            $display("FAIL signs_%0d: got k=%0d lo=%h hi=%h zero=%b want k=33 lo=%h hi=%h zero=0",
                     i, k, Lo, Hi, DivZero, eq[i], er[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_div_zero();
      int k;
      start(32'd100, 32'd7);
      wait_done(k);
      start(32'd5, 32'd0);
      total_cnt++;
      if (DivZero !== 1'b1) $display("FAIL zero_flag: got %b want 1", DivZero); else pass_cnt++;
      total_cnt++;
      if (DivDone !== 1'b1) $display("FAIL zero_done: got %b want 1", DivDone); else pass_cnt++;
      total_cnt++;
      if (Lo !== 32'd14 || Hi !== 32'd2)
         $display("FAIL zero_hold: got lo=%h hi=%h want lo=%h hi=%h", Lo, Hi, 32'd14, 32'd2);
      else pass_cnt++;
      total_cnt++;
      if (DivBusy !== 1'b0) $display("FAIL zero_busy: got %b want 0", DivBusy); else pass_cnt++;
      @(posedge clock);
      #1;
      total_cnt++;
      if (DivDone !== 1'b0 || DivZero !== 1'b1)
         $display("FAIL zero_sticky: got done=%b zero=%b want done=0 zero=1", DivDone, DivZero);
      else pass_cnt++;
      start(32'd9, 32'd3);
      total_cnt++;
      if (DivZero !== 1'b0) $display("FAIL zero_clear: got %b want 0", DivZero); else pass_cnt++;
      wait_done(k);
      total_cnt++;
      if (k != 33 || Lo !== 32'd3 || Hi !== 32'd0)
         $display("FAIL zero_next: got k=%0d lo=%h hi=%h want k=33 lo=%h hi=%h", k, Lo, Hi, 32'd3, 32'd0);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int dones;
      start(32'd100, 32'd7);
      // Start task returns after edge N; reset takes effect at edge N+10.
      repeat (9) @(negedge clock);
      DivReset = 1'b1;
      @(negedge clock);
      DivReset = 1'b0;
      total_cnt++;
      if (Hi !== 32'd0 || Lo !== 32'd0 || DivDone !== 1'b0 || DivZero !== 1'b0 || DivBusy !== 1'b0)
         $display("FAIL midreset_outputs: got hi=%h lo=%h done=%b zero=%b busy=%b want all 0",
                  Hi, Lo, DivDone, DivZero, DivBusy);
      else pass_cnt++;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (DivDone === 1'b1) dones++;
      end
      total_cnt++;
      if (dones != 0) $display("FAIL midreset_no_done: got %0d pulses want 0", dones); else pass_cnt++;
   endtask

   task automatic test_abort();
      int dones;
      int first_k;
      logic [31:0] lo_seen;
      logic [31:0] hi_seen;
      start(32'd100, 32'd7);
      repeat (4) @(negedge clock);
      start(32'd1000, 32'hFFFFFFDF);
      dones = 0;
      first_k = -1;
      lo_seen = 32'd0;
      hi_seen = 32'd0;
      for (int i = 1; i <= 45; i++) begin
         @(posedge clock);
         #1;
         if (DivDone === 1'b1) begin
            dones++;
            if (dones == 1) begin
               first_k = i;
               lo_seen = Lo;
               hi_seen = Hi;
            end
         end
      end
      total_cnt++;
      if (dones != 1) $display("FAIL abort_done_count: got %0d want 1", dones); else pass_cnt++;
      total_cnt++;
      if (first_k != 33) $display("FAIL abort_latency: got %0d want 33", first_k); else pass_cnt++;
      total_cnt++;
      if (lo_seen !== 32'hFFFFFFE2 || hi_seen !== 32'd10)
         $display("FAIL abort_result: got lo=%h hi=%h want lo=%h hi=%h",
                  lo_seen, hi_seen, 32'hFFFFFFE2, 32'd10);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      DivReset  = 1'b1;
      DivCtrl   = 1'b0;
      A         = 32'd0;
      B         = 32'd0;
      test_reset();
      test_basic();
      test_signs();
      test_div_zero();
      test_reset_mid();
      test_abort();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
